// File: rtl/qk_sequencer_pkg.sv
// Shared types and constants for the Q/K sequencer: FSM states, instruction
// bit positions and parameter defaults.
package qk_sequencer_pkg;

    localparam int COL_DEF    = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int INST_W     = 17;

    localparam int OFIFO_RD   = 16;
    localparam int QK_ADD_MSB = 15;
    localparam int QK_ADD_LSB = 12;
    localparam int P_ADD_MSB  = 11;
    localparam int P_ADD_LSB  = 8;
    localparam int EXECUTE    = 7;
    localparam int KLOAD_SEL  = 6;
    localparam int QMEM_RD    = 5;
    localparam int QMEM_WR    = 4;
    localparam int KMEM_RD    = 3;
    localparam int KMEM_WR    = 2;
    localparam int PMEM_RD    = 1;
    localparam int PMEM_WR    = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KLOAD  = 3'd1,
        ST_KFLUSH = 3'd2,
        ST_EXEC   = 3'd3,
        ST_EFLUSH = 3'd4,
        ST_WB     = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/qk_inst_enc.sv
// Maps the upcoming state, address and host fields onto the 17-bit core
// instruction word; purely combinational, the top registers the result.
module qk_inst_enc
    import qk_sequencer_pkg::*;
(
    input  state_t            i_state,
    input  logic [3:0]        i_addr,
    input  logic              i_wb_wr,
    input  logic              i_host_wr_q,
    input  logic              i_host_wr_k,
    input  logic              i_host_rd_p,
    input  logic [3:0]        i_host_addr,
    output logic [INST_W-1:0] o_inst
);

    // instruction word decode for the state being entered
    always_comb begin
        o_inst = {INST_W{1'b0}};
        case (i_state)
            ST_IDLE: begin
                if (i_host_wr_q) begin
                    o_inst[QMEM_WR]                = 1'b1;
                    o_inst[QK_ADD_MSB:QK_ADD_LSB]  = i_host_addr;
                end else if (i_host_wr_k) begin
                    o_inst[KMEM_WR]                = 1'b1;
                    o_inst[QK_ADD_MSB:QK_ADD_LSB]  = i_host_addr;
                end else if (i_host_rd_p) begin
                    o_inst[PMEM_RD]                = 1'b1;
                    o_inst[P_ADD_MSB:P_ADD_LSB]    = i_host_addr;
                end else begin
                    o_inst = {INST_W{1'b0}};
                end
            end
            ST_KLOAD: begin
                // kernel data arrives one cycle after the first kmem read
                o_inst[KMEM_RD]                    = 1'b1;
                o_inst[QK_ADD_MSB:QK_ADD_LSB]      = i_addr;
                o_inst[KLOAD_SEL]                  = (i_addr != 4'd0);
            end
            ST_KFLUSH: begin
                o_inst[KLOAD_SEL]                  = 1'b1;
            end
            ST_EXEC: begin
                o_inst[QMEM_RD]                    = 1'b1;
                o_inst[QK_ADD_MSB:QK_ADD_LSB]      = i_addr;
                o_inst[EXECUTE]                    = (i_addr != 4'd0);
            end
            ST_EFLUSH: begin
                o_inst[EXECUTE]                    = 1'b1;
            end
            ST_WB: begin
                if (i_wb_wr) begin
                    o_inst[OFIFO_RD]               = 1'b1;
                    o_inst[PMEM_WR]                = 1'b1;
                    o_inst[P_ADD_MSB:P_ADD_LSB]    = i_addr;
                end else begin
                    o_inst = {INST_W{1'b0}};
                end
            end
            ST_DONE: begin
                o_inst = {INST_W{1'b0}};
            end
            default: begin
                o_inst = {INST_W{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/qk_sequencer.sv
// Sequencer for the Q/K attention core: kernel load, Q execution and psum
// write-back, plus host memory access while idle. All outputs are registered.
module qk_sequencer
    import qk_sequencer_pkg::*;
#(
    parameter int COL   = COL_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        q_len,
    input  logic              abort,
    input  logic              host_wr_q,
    input  logic              host_wr_k,
    input  logic              host_rd_p,
    input  logic [3:0]        host_addr,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] W_QLEN_MAX = 5'(DEPTH);
    localparam logic [4:0] W_COL_LAST = 5'(COL - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [4:0]          r_cnt;
    logic [4:0]          w_cnt_next;
    logic [4:0]          r_qlen;
    logic [4:0]          w_qlen_next;
    logic [4:0]          w_qlen_sat;
    logic                w_wb_wr;
    logic                w_hwq;
    logic                w_hwk;
    logic                w_hrp;
    logic [3:0]          w_enc_addr;
    logic [INST_W-1:0]   w_inst;
    logic [INST_W-1:0]   r_inst;
    logic                r_busy;
    logic                r_done;

    assign w_qlen_sat = (q_len > W_QLEN_MAX) ? W_QLEN_MAX : q_len;

    // next-state, counter and host-command selection
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_qlen_next  = r_qlen;
        w_wb_wr      = 1'b0;
        w_hwq        = 1'b0;
        w_hwk        = 1'b0;
        w_hrp        = 1'b0;
        if ((r_state != ST_IDLE) && abort) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_qlen_next  = w_qlen_sat;
                        w_cnt_next   = 5'd0;
                        w_state_next = (w_qlen_sat == 5'd0) ? ST_DONE : ST_KLOAD;
                    end else begin
                        w_hwq = host_wr_q;
                        w_hwk = host_wr_k;
                        w_hrp = host_rd_p;
                    end
                end
                ST_KLOAD: begin
                    if (r_cnt == W_COL_LAST) begin
                        w_state_next = ST_KFLUSH;
                        w_cnt_next   = 5'd0;
                    end else begin
                        w_cnt_next   = r_cnt + 5'd1;
                    end
                end
                ST_KFLUSH: begin
                    w_state_next = ST_EXEC;
                    w_cnt_next   = 5'd0;
                end
                ST_EXEC: begin
                    if (r_cnt == (r_qlen - 5'd1)) begin
                        w_state_next = ST_EFLUSH;
                        w_cnt_next   = 5'd0;
                    end else begin
                        w_cnt_next   = r_cnt + 5'd1;
                    end
                end
                ST_EFLUSH, ST_WB: begin
                    // r_cnt counts writes already issued; a valid row is
                    // written in the next cycle at that address
                    if ((r_state == ST_WB) && (r_cnt >= r_qlen)) begin
                        w_state_next = ST_DONE;
                        w_cnt_next   = 5'd0;
                    end else if (ofifo_valid) begin
                        w_state_next = ST_WB;
                        w_wb_wr      = 1'b1;
                        w_cnt_next   = r_cnt + 5'd1;
                    end else begin
                        w_state_next = ST_WB;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 5'd0;
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 5'd0;
                end
            endcase
        end
    end

    assign w_enc_addr = w_wb_wr ? r_cnt[3:0] : w_cnt_next[3:0];

    qk_inst_enc u_enc (
        .i_state     (w_state_next),
        .i_addr      (w_enc_addr),
        .i_wb_wr     (w_wb_wr),
        .i_host_wr_q (w_hwq),
        .i_host_wr_k (w_hwk),
        .i_host_rd_p (w_hrp),
        .i_host_addr (host_addr),
        .o_inst      (w_inst)
    );

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_qlen  <= 5'd0;
            r_inst  <= {INST_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_qlen  <= w_qlen_next;
            r_inst  <= w_inst;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    assign inst = r_inst;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: doc/qk_sequencer.md
QK_SEQUENCER -- requirements
Module: qk_sequencer

Interface
REQ-001 The block SHALL have parameter COL, default 8, giving the number of kernel rows loaded into mac_array, one per column.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the Q/K/psum memory depth; address width is 4.
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a pass.
- q_len  in  5  number of Q vectors in the pass, 0..16.
- abort  in  1  synchronous abort of the pass.
- host_wr_q  in  1  host write to qmem.
- host_wr_k  in  1  host write to kmem.
- host_rd_p  in  1  host read from pmem.
- host_addr  in  4  host memory address.
- ofifo_valid  in  1  core output FIFO holds a complete row.
- inst  out  17  core instruction word.
- busy  out  1  a pass is in progress.
- done  out  1  one-cycle pulse at pass end.

Function
REQ-004 The inst field map SHALL be:
- [16] ofifo_rd
- [15:12] qkmem_add
- [11:8] pmem_add
- [7] execute
- [6] kernel-load/kmem mux select
- [5] qmem_rd
- [4] qmem_wr
- [3] kmem_rd
- [2] kmem_wr
- [1] pmem_rd
- [0] pmem_wr
REQ-005 The FSM SHALL have the states IDLE, KLOAD, KFLUSH, EXEC, EFLUSH, WB and DONE, each with a registered output.
REQ-006 In IDLE:
- host_wr_q SHALL drive inst[4] with qkmem_add=host_addr.
- host_wr_k SHALL drive inst[2] with qkmem_add=host_addr.
- host_rd_p SHALL drive inst[1] with pmem_add=host_addr.
- Each host command SHALL appear on inst in the cycle after it is sampled.
REQ-007 In IDLE, the host command priority SHALL be start > host_wr_q > host_wr_k > host_rd_p; lower-priority commands in the same cycle SHALL be dropped.
REQ-008 Host commands SHALL be ignored while busy=1.
REQ-009 start with q_len=0 SHALL go IDLE->DONE directly: done pulses, and no memory access occurs.
REQ-010 start with q_len>0 SHALL enter KLOAD in the next cycle.
REQ-011 KLOAD SHALL last COL cycles:
- inst[3]=1 and qkmem_add=0..COL-1 in consecutive cycles.
- inst[6]=1 from the second KLOAD cycle onward, because the SRAM read latency is one cycle.
REQ-012 KFLUSH SHALL last one cycle with inst[6]=1 and inst[3]=0, then go to EXEC.
REQ-013 EXEC SHALL last q_len cycles:
- inst[5]=1 and qkmem_add=0..q_len-1 in consecutive cycles.
- inst[7]=1 from the second EXEC cycle onward.
REQ-014 EFLUSH SHALL last one cycle with inst[7]=1, then go to WB.
REQ-015 In WB, each cycle with ofifo_valid=1 SHALL assert inst[16] and inst[0] together, with pmem_add = write count (0..q_len-1).
REQ-016 WB SHALL leave for DONE in the cycle after the q_len-th write; cycles with ofifo_valid=0 SHALL stall WB with no time limit.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 abort=1 in any non-IDLE state SHALL force IDLE in the next cycle: inst=0 and no done pulse.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 q_len SHALL be latched on start; values greater than 16 SHALL saturate to 16.
REQ-022 The address counters SHALL be 5 bits wide internally and SHALL never wrap past DEPTH-1.
REQ-023 In every cycle with no activity, inst SHALL be all zero.

Reset
REQ-024 reset=0 SHALL asynchronously force:
- state=IDLE
- inst=0, busy=0, done=0
- all counters and the latched q_len to 0
REQ-025 Reset mid-pass SHALL abandon the pass without a done pulse; the first start after release SHALL run a full pass.

Structure
REQ-026 A shared package SHALL hold:
- the state enum
- the inst bit-position constants (OFIFO_RD=16, QK_ADD_MSB=15, ...)
- the COL and DEPTH defaults
REQ-027 The instruction encoder SHALL be one sub-module, qk_inst_enc, mapping state, counters and host fields to the 17-bit word; the FSM and counters SHALL live in qk_sequencer.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- start with q_len=4 and COL=8, ofifo_valid held 1 -> KLOAD 8 cycles (addresses 0-7), inst[6] for 8 cycles, EXEC 4 cycles, 4 WB writes to pmem addresses 0-3, done at cycle 1+8+1+4+1+4+1=20.
- WB with ofifo_valid toggling 1,0,0,1,1,0,1 and q_len=4 -> pmem writes at addresses 0,1,2,3 only in the valid cycles, then done one cycle after the 4th write.
- start with q_len=0 -> done in the cycle after start, inst stays 0.
- abort in the 3rd EXEC cycle -> IDLE next cycle, inst=0, done never asserted; a following start with q_len=2 completes normally.
- reset pulled low in the 5th KLOAD cycle -> all outputs 0 asynchronously; after release, host_wr_q with addr=7 -> inst=0x07010 in the next cycle.
- host_wr_k with host_rd_p in the same IDLE cycle -> only inst[2] is asserted; host_wr_q during busy -> ignored.
